// File: rtl/tx_startup_fsm_pkg.sv
// tx_startup_pkg: state encoding and timer sizing shared by the TX start-up sequencer.
package tx_startup_pkg;
  typedef enum logic [3:0] {
    INIT             = 4'd0,
    ASSERT_PLL_RESET = 4'd1,
    WAIT_PLL_LOCK    = 4'd2,
    WAIT_RESET_DONE  = 4'd3,
    WAIT_PHALIGN     = 4'd4,
    DONE             = 4'd5
  } state_t;

  function automatic int timer_w(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/tx_startup_fsm_if.sv
// tx_startup_fsm_if: GT/PLL control and status bundle; master is the sequencer, slave the transceiver side.
interface tx_startup_fsm_if #(parameter int RETRY_W = 4);
  logic               pll_lock_i;
  logic               tx_reset_done_i;
  logic               phase_alignment_done_i;
  logic               pll_reset_o;
  logic               gt_tx_reset_o;
  logic               tx_user_rdy_o;
  logic               reset_phalignment_o;
  logic               run_phalignment_o;
  logic               tx_fsm_reset_done_o;
  logic [RETRY_W-1:0] retry_count_o;
  modport master (
    input  pll_lock_i, tx_reset_done_i, phase_alignment_done_i,
    output pll_reset_o, gt_tx_reset_o, tx_user_rdy_o, reset_phalignment_o,
           run_phalignment_o, tx_fsm_reset_done_o, retry_count_o
  );
  modport slave (
    output pll_lock_i, tx_reset_done_i, phase_alignment_done_i,
    input  pll_reset_o, gt_tx_reset_o, tx_user_rdy_o, reset_phalignment_o,
           run_phalignment_o, tx_fsm_reset_done_o, retry_count_o
  );
endinterface

// File: rtl/sync_block.sv
// sync_block: multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_block #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk)
    r_sync <= {r_sync[STAGES-2:0], i_d};
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/tx_startup_fsm.sv
// tx_startup_fsm: GTX TX bring-up sequencer (PLL reset, lock, GT reset, phase align) with timeout retries.
module tx_startup_fsm
  import tx_startup_pkg::*;
#(
  parameter int INIT_WAIT_CYCLES = 500,
  parameter int PLL_RESET_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 100000,
  parameter int RETRY_W          = 4
) (
  input  logic                stable_clk_i,
  input  logic                soft_reset_i,
  tx_startup_fsm_if.master    bus
);
  localparam int TW = timer_w(INIT_WAIT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_INIT = TW'(INIT_WAIT_CYCLES - 1);
  localparam logic [TW-1:0] T_PLL  = TW'(PLL_RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_TO   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic [RETRY_W-1:0] r_retry;
  logic               r_pll_reset, r_gt_tx_reset, r_tx_user_rdy;
  logic               r_reset_ph, r_run_ph, r_done;
  logic               w_pll_lock_s, w_tx_reset_done_s, w_timeout, w_retry;

  sync_block u_sync_lock (.clk(stable_clk_i), .i_d(bus.pll_lock_i),      .o_q(w_pll_lock_s));
  sync_block u_sync_rdone(.clk(stable_clk_i), .i_d(bus.tx_reset_done_i), .o_q(w_tx_reset_done_s));

  assign w_timeout = r_timer == T_TO;
  // Loss of lock outranks success; success outranks a coincident timeout.
  assign w_retry =
      (r_state == WAIT_PLL_LOCK)   ? !w_pll_lock_s && w_timeout :
      (r_state == WAIT_RESET_DONE) ? !w_pll_lock_s || (!w_tx_reset_done_s && w_timeout) :
      (r_state == WAIT_PHALIGN)    ? !w_pll_lock_s || (!bus.phase_alignment_done_i && w_timeout) :
      (r_state == DONE)            ? !w_pll_lock_s : 1'b0;

  always_ff @(posedge stable_clk_i) begin
    if (soft_reset_i) begin
      r_state       <= INIT;
      r_timer       <= '0;
      r_retry       <= '0;
      r_pll_reset   <= 1'b0;
      r_gt_tx_reset <= 1'b1;
      r_tx_user_rdy <= 1'b0;
      r_reset_ph    <= 1'b1;
      r_run_ph      <= 1'b0;
      r_done        <= 1'b0;
    end else if (w_retry) begin
      r_state       <= ASSERT_PLL_RESET;
      r_timer       <= '0;
      r_retry       <= (r_retry == '1) ? r_retry : r_retry + 1'b1;
      r_pll_reset   <= 1'b1;
      r_gt_tx_reset <= 1'b1;
      r_tx_user_rdy <= 1'b0;
      r_reset_ph    <= 1'b1;
      r_run_ph      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_timer <= (r_timer == T_MAX) ? r_timer : r_timer + 1'b1;
      case (r_state)
        INIT:
          if (r_timer == T_INIT) begin
            r_state     <= ASSERT_PLL_RESET;
            r_timer     <= '0;
            r_pll_reset <= 1'b1;
          end
        ASSERT_PLL_RESET:
          if (r_timer == T_PLL) begin
            r_state     <= WAIT_PLL_LOCK;
            r_timer     <= '0;
            r_pll_reset <= 1'b0;
          end
        WAIT_PLL_LOCK:
          if (w_pll_lock_s) begin
            r_state       <= WAIT_RESET_DONE;
            r_timer       <= '0;
            r_gt_tx_reset <= 1'b0;
            r_tx_user_rdy <= 1'b1;
          end
        WAIT_RESET_DONE:
          if (w_tx_reset_done_s) begin
            r_state    <= WAIT_PHALIGN;
            r_timer    <= '0;
            r_reset_ph <= 1'b0;
            r_run_ph   <= 1'b1;
          end
        WAIT_PHALIGN:
          if (bus.phase_alignment_done_i) begin
            r_state <= DONE;
            r_timer <= '0;
            r_done  <= 1'b1;
          end
        default: ;
      endcase
    end
  end

  assign bus.pll_reset_o         = r_pll_reset;
  assign bus.gt_tx_reset_o       = r_gt_tx_reset;
  assign bus.tx_user_rdy_o       = r_tx_user_rdy;
  assign bus.reset_phalignment_o = r_reset_ph;
  assign bus.run_phalignment_o   = r_run_ph;
  assign bus.tx_fsm_reset_done_o = r_done;
  assign bus.retry_count_o       = r_retry;
endmodule
